ps2_scan_decoder: RTL and testbench

Sits directly downstream of the PS/2 keyboard controller (PS2_Interface) and upstream of the scancode-to-ASCII converter, LCD and VGA control logic. Consumes the raw set-2 byte stream (one-cycle strobe plus byte) and strips E0/F0 prefixes and keyboard housekeeping bytes. Emits complete key events {ext, break, code} through a small FWFT FIFO with valid/ready handshake. Also tracks shift-key state for the converter.

---
 rtl/ps2_scan_decoder.sv | 175 +++++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 scancode decoder.
// Folds E0/F0 prefixes into complete key events {ext, break, code}, drops keyboard
// housekeeping bytes and queues the events in a small first-word-fall-through FIFO.
// Also tracks whether either shift key is currently held.
module ps2_scan_decoder #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              key_strobe,
  input  logic [7:0]        key_byte,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [7:0]        evt_code,
  output logic              evt_ext,
  output logic              evt_break,
  output logic              shift_held,
  output logic              overflow,
  output logic [ADDR_W:0]   fifo_count
);

  localparam logic [19:0]     TimeoutLast = 20'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W:0] DepthCnt    = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk
  } state_e;

  state_e state_q, state_d;
  logic [19:0] tmo_q;

  logic is_e0, is_f0, is_housekeeping;
  logic emit, emit_ext, emit_brk;

  assign is_e0 = (key_byte == 8'hE0);
  assign is_f0 = (key_byte == 8'hF0);
  assign is_housekeeping = (key_byte == 8'h00) || (key_byte == 8'hAA) ||
                           (key_byte == 8'hEE) || (key_byte == 8'hFA) ||
                           (key_byte == 8'hFE) || (key_byte == 8'hFF);

  // Prefix decode: next state and whether this strobe completes an event.
  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    if (key_strobe) begin
      unique case (state_q)
        StIdle: begin
          if (is_e0) begin
            state_d = StExt;
          end else if (is_f0) begin
            state_d = StBrk;
          end else if (!is_housekeeping) begin
            emit = 1'b1;
          end
        end
        StExt: begin
          if (is_f0) begin
            state_d = StExtBrk;
          end else if (!is_e0) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            state_d  = StIdle;
          end
        end
        StBrk: begin
          if (is_e0) begin
            state_d = StExtBrk;
          end else if (!is_f0) begin
            emit     = 1'b1;
            emit_brk = 1'b1;
            state_d  = StIdle;
          end
        end
        StExtBrk: begin
          if (!is_e0 && !is_f0) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            emit_brk = 1'b1;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if ((state_q != StIdle) && (tmo_q == TimeoutLast)) begin
      // A stalled prefix sequence is abandoned without emitting anything.
      state_d = StIdle;
    end
  end

  // Decoder state and prefix-idle timeout counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      if (key_strobe || (state_q == StIdle) || (tmo_q == TimeoutLast)) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + 20'd1;
      end
    end
  end

  // Shift tracking follows every decoded event, including ones the FIFO drops.
  logic shift_l_q, shift_r_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shift_l_q <= 1'b0;
      shift_r_q <= 1'b0;
    end else if (emit && !emit_ext) begin
      if (key_byte == 8'h12) shift_l_q <= !emit_brk;
      if (key_byte == 8'h59) shift_r_q <= !emit_brk;
    end
  end

  assign shift_held = shift_l_q | shift_r_q;

  // Event FIFO
  logic [9:0]        mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              overflow_q;
  logic              full, pop, do_write;

  assign full     = (count_q == DepthCnt);
  assign pop      = evt_valid & evt_ready;
  // When full, a push only fits if the head leaves on the same edge.
  assign do_write = emit && (!full || pop);

  // FIFO storage, pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_write) begin
        mem_q[wr_ptr_q] <= {emit_ext, emit_brk, key_byte};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (emit && !do_write) begin
        overflow_q <= 1'b1;
      end
      unique case ({do_write, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign evt_valid  = (count_q != '0);
  assign evt_ext    = mem_q[rd_ptr_q][9];
  assign evt_break  = mem_q[rd_ptr_q][8];
  assign evt_code   = mem_q[rd_ptr_q][7:0];
  assign overflow   = overflow_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: directed scenarios plus random byte streams, all checked
// against a queue-based event model of the decoder.
module tb_ps2_scan_decoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned TMO   = 40;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          key_strobe = 1'b0;
  logic [7:0]    key_byte = 8'h00;
  logic          evt_ready = 1'b0;
  logic          evt_valid;
  logic [7:0]    evt_code;
  logic          evt_ext;
  logic          evt_break;
  logic          shift_held;
  logic          overflow;
  logic [AW:0]   fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  ps2_scan_decoder #(
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (AW),
    .TIMEOUT_CYC(TMO)
  ) u_dut (
    .clock     (clock),
    .resetn    (resetn),
    .key_strobe(key_strobe),
    .key_byte  (key_byte),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_break (evt_break),
    .shift_held(shift_held),
    .overflow  (overflow),
    .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  // Reference model: pending prefix flags, idle counter, event queue.
  logic [9:0]  mq[$];
  bit          m_pfx, m_ext, m_brk, m_ovf, m_sl, m_sr;
  int unsigned m_idle;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_hk(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFA) ||
           (b == 8'hFE) || (b == 8'hFF);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pfx = 0; m_ext = 0; m_brk = 0; m_ovf = 0; m_sl = 0; m_sr = 0; m_idle = 0;
  endtask

  task automatic model_step(input bit s, input logic [7:0] b, input bit r);
    bit pop, emit, e, k;
    pop  = (mq.size() != 0) && r;
    emit = 0; e = 0; k = 0;
    if (s) begin
      m_idle = 0;
      if (b == 8'hE0) begin
        m_pfx = 1; m_ext = 1;
      end else if (b == 8'hF0) begin
        m_pfx = 1; m_brk = 1;
      end else if (!(!m_pfx && is_hk(b))) begin
        emit = 1; e = m_ext; k = m_brk;
        m_pfx = 0; m_ext = 0; m_brk = 0;
      end
    end else if (m_pfx) begin
      if (m_idle == TMO - 1) begin
        m_pfx = 0; m_ext = 0; m_brk = 0; m_idle = 0;
      end else begin
        m_idle++;
      end
    end
    if (pop) void'(mq.pop_front());
    if (emit) begin
      if (!e && b == 8'h12) m_sl = !k;
      if (!e && b == 8'h59) m_sr = !k;
      if (mq.size() < DEPTH) mq.push_back({e, k, b});
      else m_ovf = 1;
    end
  endtask

  task automatic compare_model();
    logic [9:0] head;
    check_val("valid", 32'(evt_valid), 32'(mq.size() != 0));
    check_val("count", 32'(fifo_count), 32'(mq.size()));
    check_val("overflow", 32'(overflow), 32'(m_ovf));
    check_val("shift_held", 32'(shift_held), 32'(m_sl | m_sr));
    if (mq.size() != 0) begin
      head = mq[0];
      check_val("head_code", 32'(evt_code), 32'(head[7:0]));
      check_val("head_ext", 32'(evt_ext), 32'(head[9]));
      check_val("head_brk", 32'(evt_break), 32'(head[8]));
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after.
  task automatic step(input bit s, input logic [7:0] b, input bit r);
    key_strobe = s;
    key_byte   = b;
    evt_ready  = r;
    @(posedge clock);
    model_step(s, b, r);
    #1;
    compare_model();
  endtask

  task automatic drain();
    repeat (DEPTH + 2) step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_valid"}, 32'(evt_valid), 32'd0);
    check_val({tag, "_code"}, 32'(evt_code), 32'd0);
    check_val({tag, "_ext"}, 32'(evt_ext), 32'd0);
    check_val({tag, "_brk"}, 32'(evt_break), 32'd0);
    check_val({tag, "_shift"}, 32'(shift_held), 32'd0);
    check_val({tag, "_ovf"}, 32'(overflow), 32'd0);
    check_val({tag, "_count"}, 32'(fifo_count), 32'd0);
  endtask

  function automatic logic [7:0] pick_byte();
    logic [7:0] hk [6];
    hk = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    case ($urandom_range(0, 9))
      0: return 8'hE0;
      1: return 8'hF0;
      2: return hk[$urandom_range(0, 5)];
      3: return 8'h12;
      4: return 8'h59;
      5: return 8'h1C;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    model_reset();
    #1;
    check_all_zero("reset");
    @(posedge clock);
    #1;
    resetn = 1'b1;

    // Single make, then pop.
    step(1'b1, 8'h1C, 1'b0);
    check_val("t1_valid", 32'(evt_valid), 32'd1);
    check_val("t1_count", 32'(fifo_count), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    check_val("t1_popped", 32'(evt_valid), 32'd0);

    // Extended break.
    step(1'b1, 8'hE0, 1'b0);
    step(1'b1, 8'hF0, 1'b0);
    check_val("t2_no_evt", 32'(evt_valid), 32'd0);
    step(1'b1, 8'h75, 1'b0);
    check_val("t2_code", 32'(evt_code), 32'h75);
    check_val("t2_extbrk", 32'({evt_ext, evt_break}), 32'd3);
    drain();

    // Shift tracking and fake shift.
    step(1'b1, 8'h12, 1'b0);
    check_val("t3_shift_set", 32'(shift_held), 32'd1);
    step(1'b1, 8'h1C, 1'b0);
    step(1'b1, 8'hF0, 1'b0);
    step(1'b1, 8'h12, 1'b0);
    check_val("t3_shift_clr", 32'(shift_held), 32'd0);
    drain();
    step(1'b1, 8'hE0, 1'b0);
    step(1'b1, 8'h12, 1'b0);
    check_val("t3_fake_shift", 32'(shift_held), 32'd0);
    drain();

    // Overflow, then push+pop while full.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    check_val("t4_count", 32'(fifo_count), 32'd4);
    check_val("t4_ovf", 32'(overflow), 32'd1);
    check_val("t4_head", 32'(evt_code), 32'h20);
    step(1'b1, 8'h2A, 1'b1);
    check_val("t4_full_pp", 32'(fifo_count), 32'd4);
    check_val("t4_head2", 32'(evt_code), 32'h21);
    drain();

    // Timeout exactly at the limit, and a strobe one cycle before it.
    step(1'b1, 8'hF0, 1'b0);
    repeat (TMO) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h1C, 1'b0);
    check_val("t5_tmo_make", 32'(evt_break), 32'd0);
    drain();
    step(1'b1, 8'hF0, 1'b0);
    repeat (TMO - 1) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h1C, 1'b0);
    check_val("t5_edge_brk", 32'(evt_break), 32'd1);
    drain();

    // Async reset mid-sequence with queued events.
    step(1'b1, 8'h12, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'hE0, 1'b0);
    key_strobe = 1'b0;
    resetn = 1'b0;
    #1;
    check_all_zero("t6_reset");
    model_reset();
    @(posedge clock);
    #1;
    resetn = 1'b1;
    step(1'b1, 8'h1C, 1'b0);
    check_val("t6_valid", 32'(evt_valid), 32'd1);
    check_val("t6_ext", 32'(evt_ext), 32'd0);
    drain();

    // Random streams with occasional long gaps to exercise the timeout.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        repeat (TMO + 5) step(1'b0, 8'h00, $urandom_range(0, 1) == 1);
      end else begin
        step($urandom_range(0, 99) < 60, pick_byte(), $urandom_range(0, 99) < 40);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
